// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver.
// Synchronises the RX line, finds the start-bit falling edge, samples every bit
// at its mid-point with a re-timed baud counter, and hands each byte out with a
// one-cycle valid strobe (or a one-cycle frame-error strobe if the stop bit is low).

module uart_rx_core #(
   parameter int BAUD_MAX  = 10416,
   parameter int HALF_BIT  = BAUD_MAX / 2,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 iRX_en,
   input  logic                 iRX,
   output logic [DATA_BITS-1:0] oRX_data,
   output logic                 oRX_valid,
   output logic                 oRX_frame_err,
   output logic                 oRX_busy
);

   localparam int CNT_W = 14;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] BAUD_CMP = CNT_W'(BAUD_MAX);
   localparam logic [CNT_W-1:0] HALF_CMP = CNT_W'(HALF_BIT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rxState_e;

   rxState_e             state_q,    state_d;
   logic [CNT_W-1:0]     baudCnt_q,  baudCnt_d;
   logic [IDX_W-1:0]     bitIdx_q,   bitIdx_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [DATA_BITS-1:0] data_q,     data_d;
   logic                 valid_q,    valid_d;
   logic                 frameErr_q, frameErr_d;

   logic rxMeta_q;
   logic rxSync_q;
   logic rxDly_q;

   // Two-flop synchroniser for the asynchronous line plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxDly_q  <= 1'b1;
      end else begin
         rxMeta_q <= iRX;
         rxSync_q <= rxMeta_q;
         rxDly_q  <= rxSync_q;
      end
   end

   // Receiver state, baud counter, shift register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         baudCnt_q  <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baudCnt_q  <= baudCnt_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Next-state logic: the edge cycle counts as count 0, so the counter enters
   // START at 1 and every sample lands HALF_BIT + n*(BAUD_MAX+1) cycles after the edge.
   always_comb begin
      state_d    = state_q;
      baudCnt_d  = baudCnt_q + CNT_W'(1);
      bitIdx_d   = bitIdx_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      frameErr_d = 1'b0;

      if (!iRX_en) begin
         state_d   = IDLE;
         baudCnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               baudCnt_d = '0;
               if (rxDly_q && !rxSync_q) begin
                  state_d   = START;
                  baudCnt_d = CNT_W'(1);
               end
            end
            START: begin
               if (baudCnt_q == HALF_CMP) begin
                  baudCnt_d = '0;
                  bitIdx_d  = '0;
                  state_d   = rxSync_q ? IDLE : DATA;
               end
            end
            DATA: begin
               if (baudCnt_q == BAUD_CMP) begin
                  baudCnt_d         = '0;
                  shift_d[bitIdx_q] = rxSync_q;
                  if (bitIdx_q == LAST_IDX) begin
                     state_d = STOP;
                  end else begin
                     bitIdx_d = bitIdx_q + IDX_W'(1);
                  end
               end
            end
            STOP: begin
               if (baudCnt_q == BAUD_CMP) begin
                  baudCnt_d = '0;
                  state_d   = IDLE;
                  if (rxSync_q) begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end else begin
                     frameErr_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               baudCnt_d = '0;
            end
         endcase
      end
   end

   assign oRX_data      = data_q;
   assign oRX_valid     = valid_q;
   assign oRX_frame_err = frameErr_q;
   assign oRX_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against a bit-timing model of the receiver.
// The model works from absolute sample offsets after the start edge; the
// stimulus process also pins pulse timing and data with hand-computed values.

module tb_uart_rx_core;

   localparam int BAUD = 15;
   localparam int HALF = 7;
   localparam int BIT  = BAUD + 1;

   logic       clk;
   logic       reset;
   logic       iRX_en;
   logic       iRX;
   logic [7:0] oRX_data;
   logic       oRX_valid;
   logic       oRX_frame_err;
   logic       oRX_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // monitor bookkeeping
   int         validCount    = 0;
   int         errCount      = 0;
   int         lastValidCyc  = -1;
   int         lastErrCyc    = -1;
   logic [7:0] lastValidData = 8'h00;

   // model state
   logic       m1, m2, m3;
   logic       active;
   int         edgeCyc;
   int         mc;
   logic [7:0] rxByte;
   logic [7:0] expData;
   logic       expValid;
   logic       expErr;

   uart_rx_core #(
      .BAUD_MAX (BAUD),
      .HALF_BIT (HALF),
      .DATA_BITS(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .iRX_en       (iRX_en),
      .iRX          (iRX),
      .oRX_data     (oRX_data),
      .oRX_valid    (oRX_valid),
      .oRX_frame_err(oRX_frame_err),
      .oRX_busy     (oRX_busy)
   );

   // Free-running 100 MHz-style clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Posedge counter used for timing the literal expectations.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic resetModel();
      m1       = 1'b1;
      m2       = 1'b1;
      m3       = 1'b1;
      active   = 1'b0;
      edgeCyc  = 0;
      mc       = 0;
      rxByte   = 8'h00;
      expData  = 8'h00;
      expValid = 1'b0;
      expErr   = 1'b0;
   endtask

   // One clock of the model: m2 is the synchronised line in the cycle just ended,
   // m3 the one before it. Samples are taken purely by offset from the edge cycle.
   task automatic stepModel();
      logic s;
      logic sPrev;
      int   d;
      s        = m2;
      sPrev    = m3;
      expValid = 1'b0;
      expErr   = 1'b0;
      if (active) begin
         if (!iRX_en) begin
            active = 1'b0;
         end else begin
            d = mc - edgeCyc;
            if (d == HALF) begin
               if (s) active = 1'b0;
            end else if (d > HALF && d < HALF + 9 * BIT && ((d - HALF) % BIT) == 0) begin
               rxByte[(d - HALF) / BIT - 1] = s;
            end else if (d == HALF + 9 * BIT) begin
               if (s) begin
                  expValid = 1'b1;
                  expData  = rxByte;
               end else begin
                  expErr = 1'b1;
               end
               active = 1'b0;
            end
         end
      end else if (iRX_en && sPrev && !s) begin
         active  = 1'b1;
         edgeCyc = mc;
      end
      m3 = m2;
      m2 = m1;
      m1 = iRX;
      mc++;
   endtask

   // Model process: async reset clears it, every rising edge advances it.
   initial begin
      resetModel();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) resetModel();
         else        stepModel();
      end
   end

   // Compare process: every falling edge the DUT outputs must match the model.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("cmp_valid", oRX_valid, expValid);
         checkOutput("cmp_err", oRX_frame_err, expErr);
         checkOutput("cmp_busy", oRX_busy, active);
         checkOutput("cmp_data", oRX_data, expData);
      end
   end

   // Pulse monitor feeding the hand-computed checks.
   initial begin
      forever begin
         @(negedge clk);
         if (oRX_valid) begin
            validCount++;
            lastValidCyc  = cyc;
            lastValidData = oRX_data;
         end
         if (oRX_frame_err) begin
            errCount++;
            lastErrCyc = cyc;
         end
      end
   end

   // Wait until the posedge counter reaches n, then settle past the monitors.
   task automatic waitCyc(input int n);
      while (cyc < n) @(negedge clk);
      #2;
   endtask

   // Sends one 8N1 frame starting at the current falling edge; dropBit >= 0
   // pulls iRX_en low 4 clocks into that data bit and leaves it low.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                input int dropBit, output int startCyc);
      iRX      = 1'b0;
      startCyc = cyc + 1;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         iRX = data[i];
         if (i == dropBit) begin
            repeat (4) @(negedge clk);
            iRX_en = 1'b0;
            @(negedge clk);
            #2;
            checkOutput("drop_busy", oRX_busy, 1'b0);
            repeat (BIT - 5) @(negedge clk);
         end else begin
            repeat (BIT) @(negedge clk);
         end
      end
      iRX = stopBit;
      repeat (BIT) @(negedge clk);
   endtask

   // Watchdog so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios. The pulse of a frame whose line falls before posedge k0
   // appears in cycle k0+153: edge cycle k0+1, stop sample 151 later, pulse 1 later.
   initial begin
      int k0;
      int k1;
      reset  = 1'b0;
      iRX    = 1'b1;
      iRX_en = 1'b1;
      @(negedge clk);
      #2;
      checkOutput("rst_data", oRX_data, 8'h00);
      checkOutput("rst_valid", oRX_valid, 1'b0);
      checkOutput("rst_err", oRX_frame_err, 1'b0);
      checkOutput("rst_busy", oRX_busy, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // 1: clean frame 0xA5
      $display("[TB] frame 0xA5");
      applyStimulus(8'hA5, 1'b1, -1, k0);
      checkOutput("t1_count", validCount, 1);
      checkOutput("t1_cyc", lastValidCyc, k0 + 153);
      checkOutput("t1_data", lastValidData, 8'hA5);
      checkOutput("t1_err", errCount, 0);
      repeat (4) @(negedge clk);

      // 2: 4-clock low glitch
      $display("[TB] glitch");
      iRX = 1'b0;
      k0  = cyc + 1;
      repeat (4) @(negedge clk);
      iRX = 1'b1;
      waitCyc(k0 + 8);
      checkOutput("t2_busy_hi", oRX_busy, 1'b1);
      waitCyc(k0 + 9);
      checkOutput("t2_busy_lo", oRX_busy, 1'b0);
      waitCyc(k0 + 40);
      checkOutput("t2_valid", validCount, 1);
      checkOutput("t2_err", errCount, 0);
      checkOutput("t2_data", oRX_data, 8'hA5);
      @(negedge clk);

      // 3: frame 0x3C with a low stop bit, line then stays low
      $display("[TB] framing error 0x3C");
      applyStimulus(8'h3C, 1'b0, -1, k0);
      checkOutput("t3_err", errCount, 1);
      checkOutput("t3_cyc", lastErrCyc, k0 + 153);
      checkOutput("t3_valid", validCount, 1);
      waitCyc(cyc + 40);
      checkOutput("t3_busy", oRX_busy, 1'b0);
      checkOutput("t3_data", oRX_data, 8'hA5);
      checkOutput("t3_err2", errCount, 1);
      @(negedge clk);
      iRX = 1'b1;
      repeat (5) @(negedge clk);

      // 4: back-to-back 0x00 then 0xFF
      $display("[TB] back-to-back");
      applyStimulus(8'h00, 1'b1, -1, k0);
      checkOutput("t4a_cyc", lastValidCyc, k0 + 153);
      checkOutput("t4a_data", lastValidData, 8'h00);
      applyStimulus(8'hFF, 1'b1, -1, k1);
      checkOutput("t4_gap", k1 - k0, 160);
      checkOutput("t4b_cyc", lastValidCyc, k1 + 153);
      checkOutput("t4b_data", lastValidData, 8'hFF);
      checkOutput("t4_count", validCount, 3);
      checkOutput("t4_err", errCount, 1);
      repeat (3) @(negedge clk);

      // 5: enable dropped in data bit 3 of 0x5A, then a full 0x81
      $display("[TB] enable drop");
      applyStimulus(8'h5A, 1'b1, 3, k0);
      checkOutput("t5_valid", validCount, 3);
      checkOutput("t5_err", errCount, 1);
      checkOutput("t5_data", oRX_data, 8'hFF);
      iRX_en = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(8'h81, 1'b1, -1, k0);
      checkOutput("t5b_cyc", lastValidCyc, k0 + 153);
      checkOutput("t5b_data", lastValidData, 8'h81);
      repeat (3) @(negedge clk);

      // 6: async reset mid-frame, then 0xC3
      $display("[TB] async reset");
      iRX = 1'b0;
      repeat (40) @(negedge clk);
      #2;
      checkOutput("t6_busy_pre", oRX_busy, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("t6_data", oRX_data, 8'h00);
      checkOutput("t6_busy", oRX_busy, 1'b0);
      checkOutput("t6_valid", oRX_valid, 1'b0);
      checkOutput("t6_err", oRX_frame_err, 1'b0);
      iRX = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(8'hC3, 1'b1, -1, k0);
      checkOutput("t6b_cyc", lastValidCyc, k0 + 153);
      checkOutput("t6b_data", lastValidData, 8'hC3);
      checkOutput("t6_count", validCount, 5);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
